// File: rtl/prog_loader.sv
// Byte-stream program loader: frames of HDR, N, N words (MSB byte first) are written to program memory from address 0.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte over the payload.
module prog_loader #(
    parameter int unsigned IW  = 16,
    parameter int unsigned AW  = 5,
    parameter logic [7:0]  HDR = 8'hA5
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          pm_we,
    output logic [AW-1:0] pm_addr,
    output logic [IW-1:0] pm_wdata,
    output logic          cpu_hold,
    output logic          load_done,
    output logic          load_err
);

    localparam int unsigned NB  = IW / 8;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned CAP = 1 << AW;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [BCW-1:0]  byte_cnt;
    logic [AW-1:0]   word_idx;
    logic [AW-1:0]   n_last;
    logic [IW-1:0]   shift;
    logic [IW-1:0]   shift_next;
    logic            accept;
    logic            byte_last;
    logic            word_last;
    logic            count_bad;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign accept     = in_valid && in_ready;
    assign byte_last  = (byte_cnt == BCW'(NB - 1));
    assign word_last  = (word_idx == n_last);
    assign count_bad  = (in_data == 8'd0) || (32'(in_data) > CAP);
    assign shift_next = (shift << 8) | IW'(in_data);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            case (state)
                IDLE:  if (in_data == HDR) state_next = COUNT;
                COUNT: state_next = count_bad ? ERR : DATA;
                DATA: begin
                    if (byte_last && word_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        state_next = DONE;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM:  state_next = (in_data == csum) ? DONE : ERR;
`endif
                DONE,
                ERR:   if (in_data == HDR) state_next = COUNT;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status flags decode straight from the registered state, so they change the cycle after the deciding byte.
    always_comb begin
        load_done = (state == DONE);
        load_err  = (state == ERR);
        cpu_hold  = (state != DONE);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            in_ready <= 1'b0;
            pm_we    <= 1'b0;
            pm_addr  <= '0;
            pm_wdata <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            n_last   <= '0;
            shift    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            in_ready <= 1'b1;
            pm_we    <= 1'b0;
            if (accept && state == COUNT) begin
                byte_cnt <= '0;
                word_idx <= '0;
                n_last   <= AW'(in_data - 8'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end
            if (accept && state == DATA) begin
                shift <= shift_next;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum  <= csum ^ in_data;
`endif
                // pm_wdata is loaded only at word completion, so it holds while the next word shifts in.
                if (byte_last) begin
                    byte_cnt <= '0;
                    pm_we    <= 1'b1;
                    pm_addr  <= word_idx;
                    pm_wdata <= shift_next;
                    if (!word_last) word_idx <= word_idx + AW'(1);
                end else begin
                    byte_cnt <= byte_cnt + BCW'(1);
                end
            end
        end
    end

endmodule
